// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes and mux selects.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcodes trap instead of executing as NOP).
module mc_ctrl_fsm #(
  parameter int N_SEL    = 2,
  parameter int WAIT_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_re,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic [N_SEL-1:0] pc_sel,
  output logic [N_SEL-1:0] alu_a_sel,
  output logic [N_SEL-1:0] alu_b_sel,
  output logic [N_SEL-1:0] wb_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             bus_err,
  output logic             trap
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_I    = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_BNE  = 4'b0101;
  localparam logic [3:0] OP_JAL  = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [N_SEL-1:0] SEL_0 = '0;
  localparam logic [N_SEL-1:0] SEL_1 = N_SEL'(1);
  localparam logic [N_SEL-1:0] SEL_2 = N_SEL'(2);

  localparam int               CNT_W     = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             mem_phase;
  logic             timeout;
  logic             op_legal;

  // NOTE: every register is written with <= so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    op_legal  = opcode inside {OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JAL, OP_HALT};
    mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
    timeout   = mem_phase && !mem_ready && (wait_cnt_q == WAIT_LAST);
  end

  // NOTE: each output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    bus_err_d  = bus_err_q;
    wait_cnt_d = (mem_phase && !mem_ready) ? wait_cnt_q + CNT_W'(1) : '0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (!op_legal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_R, OP_I, OP_JAL: state_d = S_WB;
          OP_LW, OP_SW:       state_d = S_MEM;
          default:            state_d = S_FETCH;
        endcase
      end
      S_MEM:    if (mem_ready) state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT,
      S_TRAP:   state_d = state_q;
      default:  state_d = S_FETCH;
    endcase
    // A stalled memory access that exhausts its budget overrides any other transition.
    if (timeout) begin
      state_d    = S_HALT;
      bus_err_d  = 1'b1;
      wait_cnt_d = '0;
    end
  end

  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    pc_sel    = SEL_0;
    alu_a_sel = SEL_0;
    alu_b_sel = SEL_0;
    wb_sel    = SEL_0;
    // Strobes are gated by rst so they drop the instant reset asserts, not at the next edge.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_re = 1'b1;
          ir_we  = mem_ready;
          pc_we  = mem_ready;
        end
        S_DECODE: alu_b_sel = SEL_2;
        S_EXEC: begin
          case (opcode)
            OP_R: begin
              alu_a_sel = SEL_1;
              alu_b_sel = SEL_1;
            end
            OP_I, OP_LW, OP_SW: begin
              alu_a_sel = SEL_1;
              alu_b_sel = SEL_2;
            end
            OP_BEQ, OP_BNE: begin
              alu_a_sel = SEL_1;
              alu_b_sel = SEL_1;
              pc_sel    = SEL_1;
              pc_we     = (opcode == OP_BEQ) ? zero : !zero;
            end
            OP_JAL: begin
              pc_sel = SEL_1;
              pc_we  = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_re = (opcode == OP_LW);
          mem_we = (opcode == OP_SW);
        end
        S_WB: begin
          rf_we = 1'b1;
          if (opcode == OP_LW)       wb_sel = SEL_1;
          else if (opcode == OP_JAL) wb_sel = SEL_2;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state   = state_q;
    halted  = (state_q == S_HALT) || (state_q == S_TRAP);
    bus_err = bus_err_q;
`ifdef ILLEGAL_TRAP_EN
    trap    = (state_q == S_TRAP);
`else
    trap    = 1'b0;
`endif
  end

endmodule
